stopwatch_mux: RTL
==================

Name: stopwatch_mux

Overview:
- Next-generation stopwatch: MM:SS BCD time counter with run/pause, clear, and a field-adjust mode with blinking of the selected field.
- Drives a 4-digit, time-multiplexed, active-low seven-segment display directly.
- Sits at board top level between debounced button/switch inputs and the display pins.
- All timing comes from parameterised clock dividers, so the bench can run with small divisors.

Parameters:
- TICK_DIV, 100000000, clk cycles per 1 s count tick
- ADJ_DIV, 50000000, clk cycles per adjust increment (2 Hz)
- BLINK_DIV, 25000000, clk cycles per blink phase toggle
- SCAN_DIV, 100000, clk cycles per display digit advance
- MAX_MIN, 59, highest minute value before wrap to 0 (range 1..99)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- pause  input  1  debounced button level; each rising edge toggles run/pause
- clr  input  1  debounced level; while high, time is held at 00:00
- adj  input  1  switch; 1 = adjust mode
- sel  input  1  adjust field select; 0 = seconds, 1 = minutes
- min_bcd  output  8  minutes {tens,ones} BCD
- sec_bcd  output  8  seconds {tens,ones} BCD
- paused  output  1  1 = counting halted
- an  output  4  digit enables, active-low one-hot
- seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst=0, async): all registers clear. min_bcd=0, sec_bcd=0, paused=0, an=4'b1111, seg=8'hFF. All dividers and the scan index clear, and blink phase = 0.
- Input conditioning:
  - pause, clr, adj and sel each pass through a 2-flop synchronizer.
  - The pause rising edge is detected on the synced signal, giving a one-cycle pulse 3 clk edges after the pin rises.
- Dividers:
  - Each is a counter 0..DIV-1, with width $clog2(DIV).
  - It emits a one-cycle tick in the cycle the count equals DIV-1, then wraps to 0.
  - The 1 s divider is cleared while synced clr=1.
  - The adjust divider is held at 0 while synced adj=0.
- Priority per cycle: clr > adj > count.
  - clr=1: min=sec=0. The paused flag is unaffected.
  - adj=1: normal counting stops. On each adjust tick, the sel field increments with no carry: sec 59->00, min MAX_MIN->00.
  - Otherwise: if paused=0, then on each 1 s tick sec increments. At 59, sec goes to 00 and min increments. At MAX_MIN:59, both go to 00:00.
- Digit arithmetic:
  - Each BCD digit is held in its own register. Ones wrap 9->0 with a carry into tens.
  - Seconds tens wrap 5->0.
  - Minutes wrap at MAX_MIN, compared as full BCD.
- Pause edge: toggles paused in any mode, including adj and clr. A pause edge coinciding with a 1 s tick is applied after that tick (the tick still counts if paused was 0).
- Count update latency: new values are visible on min_bcd/sec_bcd on the clk edge after the tick cycle.
- Display scan:
  - A 2-bit index advances on each scan tick: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens.
  - an = ~(1<<index).
  - seg is the registered decode of the selected digit and updates 1 cycle after index/data change.
  - dp is always 1 (off). Digits 0-9 use the standard patterns; any code >9 blanks the digit (8'hFF).
- Blink: blink phase toggles on each blink tick. When adj=1 and phase=1, both digits of the sel field show seg=8'hFF while an still scans.
- Leaving adj: the adjusted value is kept. Counting resumes on the next 1 s tick, and the 1 s divider is not reset.
- rst asserted mid-count or mid-adjust returns immediately to the reset state. Deassertion is synchronized externally.

Test Plan (TICK_DIV=10, ADJ_DIV=5, BLINK_DIV=4, SCAN_DIV=2, MAX_MIN=2):
- Count and carry: release rst and run 600 cycles -> sec_bcd steps once per 10 cycles. After 60 ticks min_bcd=8'h01 and sec_bcd=8'h00. 00:59->01:00 occurs on a single edge.
- Wrap: preload by counting to 02:59, then one more tick -> 00:00. paused stays 0 throughout.
- Pause: pulse pause at time 00:03 -> paused=1 within 4 cycles and time frozen for 100 cycles. A second pulse -> paused=0 and counting resumes. A pause held high for 50 cycles toggles only once.
- Clear: clr=1 while running at 00:07 -> 00:00 within 3 cycles. It holds while clr=1, paused is unchanged, and the first tick after clr falls comes 10 cycles later.
- Adjust: adj=1, sel=0 at 00:58 -> sec goes 59, then 00 every 5 cycles, and min stays 00. Then sel=1 -> min goes 01, 02, 00. The sel digits read 8'hFF during blink phase 1.
- Scan/decode at 01:23: an cycles 1110, 1101, 1011, 0111 every 2 cycles. seg = 8'hB0 ("3"), 8'hA4 ("2"), 8'hF9 ("1"), 8'hC0 ("0"), each seen 1 cycle after an changes. Asserting rst mid-scan -> an=1111 and seg=FF immediately.

Source files
------------

// File: rtl/stopwatch_mux.sv
// stopwatch_mux: MM:SS BCD stopwatch driving a 4-digit multiplexed,
// active-low seven-segment display.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   pause    debounced button level; every rising edge toggles run/pause
//   clr      debounced level; while high the time is held at 00:00
//   adj      switch; 1 = field-adjust mode
//   sel      adjust field select; 0 = seconds, 1 = minutes
//   min_bcd  minutes {tens,ones} BCD
//   sec_bcd  seconds {tens,ones} BCD
//   paused   1 = counting halted
//   an       digit enables, active-low one-hot
//   seg      segments {dp,g,f,e,d,c,b,a}, active-low
//
// Per-cycle priority of the time registers is clr > adj > normal count.
// All timing comes from the *_DIV free-running dividers.
module stopwatch_mux #(
  parameter int TICK_DIV  = 100000000,
  parameter int ADJ_DIV   = 50000000,
  parameter int BLINK_DIV = 25000000,
  parameter int SCAN_DIV  = 100000,
  parameter int MAX_MIN   = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       clr,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       paused,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int ADJ_W   = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [ADJ_W-1:0]   ADJ_LAST   = ADJ_W'(ADJ_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);

  // Minute wrap point expressed as packed BCD so it compares against
  // {min_ten, min_one} directly.
  localparam logic [7:0] MAX_MIN_BCD = 8'(((MAX_MIN / 10) * 16) + (MAX_MIN % 10));

  // ---------------------------------------------------------------------
  // Input synchronizers: bit order {sel, adj, clr, pause}
  // ---------------------------------------------------------------------
  logic [3:0] sync1_q, sync2_q;
  logic       pause_s3_q;   // previous synced pause, for edge detect

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 4'b0000;
      sync2_q    <= 4'b0000;
      pause_s3_q <= 1'b0;
    end else begin
      sync1_q    <= {sel, adj, clr, pause};
      sync2_q    <= sync1_q;
      pause_s3_q <= sync2_q[0];
    end
  end

  logic pause_s, clr_s, adj_s, sel_s, pause_edge;
  assign pause_s    = sync2_q[0];
  assign clr_s      = sync2_q[1];
  assign adj_s      = sync2_q[2];
  assign sel_s      = sync2_q[3];
  assign pause_edge = pause_s & ~pause_s3_q;

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  logic [TICK_W-1:0]  tick_cnt_q,  tick_cnt_d;
  logic [ADJ_W-1:0]   adj_cnt_q,   adj_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
  logic               blink_q,     blink_d;
  logic [1:0]         scan_idx_q,  scan_idx_d;
  logic [3:0]         sec_one_q,   sec_one_d;
  logic [3:0]         sec_ten_q,   sec_ten_d;
  logic [3:0]         min_one_q,   min_one_d;
  logic [3:0]         min_ten_q,   min_ten_d;
  logic               paused_q,    paused_d;
  logic [3:0]         an_q,        an_d;
  logic [7:0]         seg_q,       seg_d;

  logic sec_tick, adj_tick, blink_tick, scan_tick;

  // ---------------------------------------------------------------------
  // Dividers
  // ---------------------------------------------------------------------
  always_comb begin
    sec_tick   = (tick_cnt_q == TICK_LAST);
    adj_tick   = adj_s && (adj_cnt_q == ADJ_LAST);
    blink_tick = (blink_cnt_q == BLINK_LAST);
    scan_tick  = (scan_cnt_q == SCAN_LAST);

    // 1 s divider restarts from zero once clr is released.
    if (clr_s || sec_tick) tick_cnt_d = '0;
    else                   tick_cnt_d = tick_cnt_q + 1'b1;

    // Adjust divider only runs in adjust mode, so the first increment
    // lands a full ADJ_DIV after adj goes high.
    if (!adj_s || adj_tick) adj_cnt_d = '0;
    else                    adj_cnt_d = adj_cnt_q + 1'b1;

    if (blink_tick) blink_cnt_d = '0;
    else            blink_cnt_d = blink_cnt_q + 1'b1;

    if (scan_tick) scan_cnt_d = '0;
    else           scan_cnt_d = scan_cnt_q + 1'b1;

    blink_d    = blink_q ^ blink_tick;
    scan_idx_d = scan_idx_q + {1'b0, scan_tick};
  end

  // ---------------------------------------------------------------------
  // Time digits and pause flag
  // ---------------------------------------------------------------------
  logic sec_at_max, min_at_max;
  assign sec_at_max = (sec_ten_q == 4'd5) && (sec_one_q == 4'd9);
  assign min_at_max = ({min_ten_q, min_one_q} == MAX_MIN_BCD);

  always_comb begin
    sec_one_d = sec_one_q;
    sec_ten_d = sec_ten_q;
    min_one_d = min_one_q;
    min_ten_d = min_ten_q;
    // The toggle uses the old paused value for this cycle's tick, so a
    // pause edge coinciding with a tick takes effect after that tick.
    paused_d  = paused_q ^ pause_edge;

    if (clr_s) begin
      sec_one_d = 4'd0;
      sec_ten_d = 4'd0;
      min_one_d = 4'd0;
      min_ten_d = 4'd0;
    end else if (adj_s) begin
      if (adj_tick) begin
        if (sel_s) begin
          if (min_at_max) begin
            min_one_d = 4'd0;
            min_ten_d = 4'd0;
          end else if (min_one_q == 4'd9) begin
            min_one_d = 4'd0;
            min_ten_d = min_ten_q + 4'd1;
          end else begin
            min_one_d = min_one_q + 4'd1;
          end
        end else begin
          // Seconds field wraps 59 -> 00 without touching minutes.
          if (sec_one_q == 4'd9) begin
            sec_one_d = 4'd0;
            sec_ten_d = (sec_ten_q == 4'd5) ? 4'd0 : sec_ten_q + 4'd1;
          end else begin
            sec_one_d = sec_one_q + 4'd1;
          end
        end
      end
    end else if (!paused_q && sec_tick) begin
      if (sec_one_q == 4'd9) begin
        sec_one_d = 4'd0;
        sec_ten_d = (sec_ten_q == 4'd5) ? 4'd0 : sec_ten_q + 4'd1;
      end else begin
        sec_one_d = sec_one_q + 4'd1;
      end
      if (sec_at_max) begin
        if (min_at_max) begin
          min_one_d = 4'd0;
          min_ten_d = 4'd0;
        end else if (min_one_q == 4'd9) begin
          min_one_d = 4'd0;
          min_ten_d = min_ten_q + 4'd1;
        end else begin
          min_one_d = min_one_q + 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Display scan and segment decode
  // ---------------------------------------------------------------------
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  logic [3:0] cur_digit;
  logic       blank;

  always_comb begin
    case (scan_idx_q)
      2'd0:    cur_digit = sec_one_q;
      2'd1:    cur_digit = sec_ten_q;
      2'd2:    cur_digit = min_one_q;
      default: cur_digit = min_ten_q;
    endcase
    // Index bit 1 distinguishes the minutes pair from the seconds pair,
    // which matches the encoding of sel.
    blank = adj_s && blink_q && (sel_s == scan_idx_q[1]);
    // an follows the index on the same edge; seg is decoded from the
    // current index/data and therefore trails both by one cycle.
    an_d  = ~(4'b0001 << scan_idx_d);
    seg_d = blank ? 8'hFF : seg_decode(cur_digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q  <= '0;
      adj_cnt_q   <= '0;
      blink_cnt_q <= '0;
      scan_cnt_q  <= '0;
      blink_q     <= 1'b0;
      scan_idx_q  <= 2'd0;
      sec_one_q   <= 4'd0;
      sec_ten_q   <= 4'd0;
      min_one_q   <= 4'd0;
      min_ten_q   <= 4'd0;
      paused_q    <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 8'hFF;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      adj_cnt_q   <= adj_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      blink_q     <= blink_d;
      scan_idx_q  <= scan_idx_d;
      sec_one_q   <= sec_one_d;
      sec_ten_q   <= sec_ten_d;
      min_one_q   <= min_one_d;
      min_ten_q   <= min_ten_d;
      paused_q    <= paused_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign min_bcd = {min_ten_q, min_one_q};
  assign sec_bcd = {sec_ten_q, sec_one_q};
  assign paused  = paused_q;
  assign an      = an_q;
  assign seg     = seg_q;

endmodule
